btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Sequences all BTB target updates from two branch-resolution requesters: requester 0 is the branch/ALU unit, requester 1 is the JALR unit.
- Accepts resolved branches through a round-robin arbiter into a small update FIFO.
- Drains each entry with a check-then-write sequence, so redundant writes are skipped.
- Sits between the execute-stage resolution buses and the BTB's check/write port. The BTB read port stays owned by fetch.

Parameters:
- FIFO_DEPTH, 4, number of queued updates; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req0_valid  in  1  requester 0 has a resolved taken branch
- req0_pc  in  32  requester 0 branch PC
- req0_target  in  32  requester 0 resolved target
- req0_ready  out  1  requester 0 accepted this cycle when valid&&ready
- req1_valid  in  1  requester 1 has a resolved taken branch
- req1_pc  in  32  requester 1 branch PC
- req1_target  in  32  requester 1 resolved target
- req1_ready  out  1  requester 1 handshake ready
- btb_check  out  1  BTB check strobe
- btb_write  out  1  BTB write strobe
- btb_pc_update  out  32  PC driven to the BTB update/check index
- btb_target  out  32  target data to the BTB write
- btb_check_data  in  32  BTB stored target, combinational from btb_pc_update while btb_check=1
- busy  out  1  FIFO non-empty or FSM not IDLE
- writes_done  out  CNT_W  BTB writes performed; saturating
- writes_skipped  out  CNT_W  updates dropped as redundant; saturating

Behaviour:
- Reset (rst=1 at posedge) sets:
  - FIFO empty; FSM=IDLE; rr_pri=0; both counters 0.
  - All outputs 0, except req0_ready/req1_ready, which follow the combinational rules below (1 for the priority owner once the FIFO is empty).
  - Reset mid-CHECK or mid-WRITE abandons the in-flight entry. No write is issued in the reset cycle.
- Arbitration (combinational):
  - full = (count==FIFO_DEPTH).
  - req0_ready = !full && (!req1_valid || rr_pri==0).
  - req1_ready = !full && (!req0_valid || rr_pri==1).
  - At most one push per cycle.
  - rr_pri toggles only on a cycle where both were valid and one was granted. It becomes the index of the loser.
  - Ready does not depend on valid of the same requester. A lone requester with a non-full FIFO is always ready.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Push and pop may occur in the same cycle. When full, a same-cycle pop does NOT raise ready; ready is registered-state based only.
- FSM (head = FIFO head entry):
  - IDLE: all strobes 0. If count>0, go to CHECK.
  - CHECK:
    - btb_check=1, btb_pc_update=head.pc.
    - If btb_check_data==head.target: pop, writes_skipped++ (saturating), go to IDLE.
    - Otherwise go to WRITE.
  - WRITE:
    - btb_write=1, btb_pc_update=head.pc, btb_target=head.target.
    - Pop, writes_done++ (saturating), go to IDLE.
- Latency:
  - Push at edge t gives CHECK in cycle t+1..t+2; precisely, IDLE is seen in the cycle after the push, then CHECK next.
  - The BTB entry is updated at the edge ending WRITE: push-edge + 3 cycles for an empty controller.
  - Throughput: one update per 3 cycles (written) or 2 cycles (skipped).
- Outside CHECK/WRITE:
  - btb_pc_update and btb_target are 0.
  - btb_check and btb_write are never both 1.
- Ordering: updates drain in acceptance order. Two updates to the same PC are both processed; the second sees the first's value in CHECK.
- Counter saturation: a counter at 2^CNT_W-1 holds its value.
- busy = (count!=0) || (state!=IDLE).

Test Plan:
- Single update: req0 pc=0x100, target=0x200; BTB entry holds 0 → btb_check pulses, then btb_write with pc=0x100, target=0x200; writes_done=1; busy falls after WRITE.
- Redundant update: BTB entry 0x100 already holds 0x200; push the same update → CHECK only, no btb_write; writes_skipped=1, writes_done=0.
- Contention: both valid for 4 cycles with an empty FIFO, rr_pri=0 → grants 0,1,0,1; FIFO drains in that order; the BTB sees four writes in grant order.
- Backpressure: hold req0 valid with FIFO_DEPTH=4 while the FSM drains → ready stays high until count=4, then 0. No entry is lost; ready re-asserts the cycle after the first pop.
- Reset mid-WRITE: assert rst during the WRITE cycle → btb_write=0 that cycle; next cycle FIFO empty, counters 0, busy=0, both ready=1.
- Saturation: force writes_done to 0xFFFF via repeated writes (or a CNT_W=2 instance reaching 3) → a further write leaves the counter unchanged.

Source files
------------

// File: rtl/btb_update_if.sv
// Execute-side resolution requesters and BTB check/write port of the BTB update controller.
// The master modport is the environment (requesters plus BTB); the slave modport is the controller.
interface btb_update_if;
    logic        req0_valid;
    logic [31:0] req0_pc;
    logic [31:0] req0_target;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_pc;
    logic [31:0] req1_target;
    logic        req1_ready;
    logic        btb_check;
    logic        btb_write;
    logic [31:0] btb_pc_update;
    logic [31:0] btb_target;
    logic [31:0] btb_check_data;

    modport master (
        output req0_valid, req0_pc, req0_target, req1_valid, req1_pc, req1_target, btb_check_data,
        input  req0_ready, req1_ready, btb_check, btb_write, btb_pc_update, btb_target
    );

    modport slave (
        input  req0_valid, req0_pc, req0_target, req1_valid, req1_pc, req1_target, btb_check_data,
        output req0_ready, req1_ready, btb_check, btb_write, btb_pc_update, btb_target
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: round-robin accepts resolved branches into a small FIFO and drains
// each entry with a check-then-write pass so that writes of an unchanged target are skipped.
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    btb_update_if.slave      bus,
    output logic             busy,
    output logic [CNT_W-1:0] writes_done,
    output logic [CNT_W-1:0] writes_skipped
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_QW = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_r;
    logic [31:0]       pc_mem_r  [FIFO_DEPTH];
    logic [31:0]       tgt_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_QW-1:0] count_r;
    logic              rr_pri_r;
    logic              check_r;
    logic              write_r;
    logic [31:0]       pc_out_r;
    logic [31:0]       tgt_out_r;
    logic [CNT_W-1:0]  done_r;
    logic [CNT_W-1:0]  skip_r;

    logic              full_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              push_s;
    logic              pop_s;
    logic              match_s;
    logic [31:0]       push_pc_s;
    logic [31:0]       push_tgt_s;
    logic [31:0]       head_pc_s;
    logic [31:0]       head_tgt_s;

    // Arbitration, push selection and head decode; ready uses registered occupancy only.
    always_comb begin
        full_s     = (count_r == CNT_QW'(FIFO_DEPTH));
        ready0_s   = !full_s && (!bus.req1_valid || (rr_pri_r == 1'b0));
        ready1_s   = !full_s && (!bus.req0_valid || (rr_pri_r == 1'b1));
        head_pc_s  = pc_mem_r[rd_ptr_r];
        head_tgt_s = tgt_mem_r[rd_ptr_r];
        match_s    = (bus.btb_check_data == head_tgt_s);
        pop_s      = ((state_r == CHECK) && match_s) || (state_r == WRITE);
        if (bus.req0_valid && ready0_s) begin
            push_s     = 1'b1;
            push_pc_s  = bus.req0_pc;
            push_tgt_s = bus.req0_target;
        end else if (bus.req1_valid && ready1_s) begin
            push_s     = 1'b1;
            push_pc_s  = bus.req1_pc;
            push_tgt_s = bus.req1_target;
        end else begin
            push_s     = 1'b0;
            push_pc_s  = 32'h0;
            push_tgt_s = 32'h0;
        end
    end

    // FIFO payload storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]  <= push_pc_s;
            tgt_mem_r[wr_ptr_r] <= push_tgt_s;
        end
    end

    // FIFO pointers, occupancy and round-robin owner (the loser of a contended grant).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_QW{1'b0}};
            rr_pri_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_QW'(1);
                2'b01:   count_r <= count_r - CNT_QW'(1);
                default: count_r <= count_r;
            endcase
            if (bus.req0_valid && bus.req1_valid && !full_s) begin
                rr_pri_r <= ~rr_pri_r;
            end
        end
    end

    // Drain FSM with registered strobes and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            check_r   <= 1'b0;
            write_r   <= 1'b0;
            pc_out_r  <= 32'h0;
            tgt_out_r <= 32'h0;
            done_r    <= {CNT_W{1'b0}};
            skip_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    write_r   <= 1'b0;
                    tgt_out_r <= 32'h0;
                    if (count_r != {CNT_QW{1'b0}}) begin
                        state_r  <= CHECK;
                        check_r  <= 1'b1;
                        pc_out_r <= head_pc_s;
                    end else begin
                        check_r  <= 1'b0;
                        pc_out_r <= 32'h0;
                    end
                end
                CHECK: begin
                    check_r <= 1'b0;
                    if (match_s) begin
                        state_r  <= IDLE;
                        pc_out_r <= 32'h0;
                        if (skip_r != {CNT_W{1'b1}}) begin
                            skip_r <= skip_r + CNT_W'(1);
                        end
                    end else begin
                        state_r   <= WRITE;
                        write_r   <= 1'b1;
                        tgt_out_r <= head_tgt_s;
                    end
                end
                WRITE: begin
                    state_r   <= IDLE;
                    write_r   <= 1'b0;
                    pc_out_r  <= 32'h0;
                    tgt_out_r <= 32'h0;
                    if (done_r != {CNT_W{1'b1}}) begin
                        done_r <= done_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    check_r   <= 1'b0;
                    write_r   <= 1'b0;
                    pc_out_r  <= 32'h0;
                    tgt_out_r <= 32'h0;
                end
            endcase
        end
    end

    // Strobes are masked while rst is high so an abandoned entry never reaches the BTB.
    assign bus.req0_ready    = ready0_s;
    assign bus.req1_ready    = ready1_s;
    assign bus.btb_check     = check_r && !rst;
    assign bus.btb_write     = write_r && !rst;
    assign bus.btb_pc_update = rst ? 32'h0 : pc_out_r;
    assign bus.btb_target    = rst ? 32'h0 : tgt_out_r;
    assign busy              = (count_r != {CNT_QW{1'b0}}) || (state_r != IDLE);
    assign writes_done       = done_r;
    assign writes_skipped    = skip_r;
endmodule
